// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared widths, types and FSM state encoding for the data cache
// Purpose: address-split widths, line geometry and the controller state type.
// Ports: none (package).
package dcache_ctrl_pkg;

    localparam int BIT_SIZE  = 32;
    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 2;
    localparam int TAG_W     = BIT_SIZE - INDEX_W - OFFSET_W - 2;
    localparam int NUM_LINES = 2 ** INDEX_W;
    localparam int WORDS     = 2 ** OFFSET_W;

    typedef logic [BIT_SIZE-1:0] word_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    localparam offset_t LAST_BEAT = offset_t'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_WDONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - core-side and memory-side bus of the data cache controller
// Purpose: bundles the MEM-stage request/response and the main-memory request port.
// Modports: slave  = cache controller view (core inputs in, memory request out)
//           master = environment view (drives core request and memory response)
interface dcache_ctrl_if;

    logic                                 core_read;
    logic                                 core_write;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] core_addr;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] core_wdata;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] core_rdata;
    logic                                 DC_stall;
    logic                                 mem_req;
    logic                                 mem_write;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] mem_addr;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] mem_wdata;
    logic [dcache_ctrl_pkg::BIT_SIZE-1:0] mem_rdata;
    logic                                 mem_ready;

    modport slave (
        input  core_read, core_write, core_addr, core_wdata, mem_rdata, mem_ready,
        output core_rdata, DC_stall, mem_req, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output core_read, core_write, core_addr, core_wdata, mem_rdata, mem_ready,
        input  core_rdata, DC_stall, mem_req, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_ram.sv
// rtl/dcache_line_ram.sv - tag, valid and data arrays of the direct-mapped cache
// Purpose: async-read / sync-write storage; only the valid bits are reset.
// Ports: clk, rst (async active-low)
//        i_rd_index/i_rd_offset -> o_rd_valid, o_rd_tag, o_rd_word (combinational read)
//        i_data_we, i_wr_index, i_wr_offset, i_wr_data (one data word per cycle)
//        i_tag_we, i_wr_tag (writes tag at i_wr_index and sets its valid bit)
module dcache_line_ram
    import dcache_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  index_t  i_rd_index,
    input  offset_t i_rd_offset,
    output logic    o_rd_valid,
    output tag_t    o_rd_tag,
    output word_t   o_rd_word,
    input  logic    i_data_we,
    input  index_t  i_wr_index,
    input  offset_t i_wr_offset,
    input  word_t   i_wr_data,
    input  logic    i_tag_we,
    input  tag_t    i_wr_tag
);

    logic [NUM_LINES-1:0] r_valid;
    tag_t                 r_tag  [NUM_LINES];
    word_t                r_data [NUM_LINES][WORDS];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_word  = r_data[i_rd_index][i_rd_offset];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
        if (i_data_we) begin
            r_data[i_wr_index][i_wr_offset] <= i_wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// Purpose: serves MEM-stage loads/stores, refills 4-word lines, drives DC_stall.
// Ports: clk, rst (async active-low)
//        bus (dcache_ctrl_if.slave): core_read/core_write/core_addr/core_wdata in,
//        core_rdata/DC_stall out; mem_req/mem_write/mem_addr/mem_wdata out,
//        mem_rdata/mem_ready in.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
);

    state_t  r_state;
    offset_t r_beat;
    logic    r_mem_req;
    logic    r_mem_write;
    word_t   r_mem_addr;
    word_t   r_mem_wdata;

    tag_t    w_tag;
    index_t  w_index;
    offset_t w_offset;
    offset_t w_beat_next;
    logic    w_rd_valid;
    tag_t    w_rd_tag;
    word_t   w_rd_word;
    logic    w_hit;
    logic    w_data_we;
    offset_t w_wr_offset;
    word_t   w_wr_data;
    logic    w_tag_we;
    logic    w_stall;
    logic    w_unused;

    // The stalled pipeline holds core_addr stable, so the refill target is taken
    // straight from it rather than from a captured copy.
    assign w_tag       = bus.core_addr[BIT_SIZE-1 -: TAG_W];
    assign w_index     = bus.core_addr[OFFSET_W+2 +: INDEX_W];
    assign w_offset    = bus.core_addr[2 +: OFFSET_W];
    assign w_beat_next = r_beat + 1'b1;
    assign w_unused    = ^bus.core_addr[1:0];

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    assign w_data_we   = bus.mem_ready &&
                         ((r_state == ST_REFILL) || ((r_state == ST_WRITE) && w_hit));
    assign w_wr_offset = (r_state == ST_REFILL) ? r_beat : w_offset;
    assign w_wr_data   = (r_state == ST_REFILL) ? bus.mem_rdata : bus.core_wdata;
    // Valid is only raised with the final beat, so an interrupted refill leaves the line invalid.
    assign w_tag_we    = bus.mem_ready && (r_state == ST_REFILL) && (r_beat == LAST_BEAT);

    dcache_line_ram u_line_ram (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_word   (w_rd_word),
        .i_data_we   (w_data_we),
        .i_wr_index  (w_index),
        .i_wr_offset (w_wr_offset),
        .i_wr_data   (w_wr_data),
        .i_tag_we    (w_tag_we),
        .i_wr_tag    (w_tag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.core_write) begin
                        r_state     <= ST_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {bus.core_addr[BIT_SIZE-1:2], 2'b00};
                        r_mem_wdata <= bus.core_wdata;
                    end else if (bus.core_read && !w_hit) begin
                        r_state     <= ST_REFILL;
                        r_beat      <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_index, offset_t'(0), 2'b00};
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ready) begin
                        r_beat <= w_beat_next;
                        if (r_beat == LAST_BEAT) begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_mem_addr <= {w_tag, w_index, w_beat_next, 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        r_state     <= ST_WDONE;
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                ST_WDONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle a miss is seen, so it is decoded from the
    // registered state plus the live hit; it is forced low while reset is held.
    always_comb begin
        w_stall = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE:   w_stall = bus.core_write || (bus.core_read && !w_hit);
                ST_REFILL: w_stall = 1'b1;
                ST_WRITE:  w_stall = 1'b1;
                default:   w_stall = 1'b0;
            endcase
        end
    end

    assign bus.DC_stall   = w_stall;
    assign bus.core_rdata = (rst && (r_state == ST_IDLE) && bus.core_read &&
                             !bus.core_write && w_hit) ? w_rd_word : '0;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
